sram_fifo_ctrl: RTL and testbench

SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

---
 rtl/sram_fifo_ctrl.sv | 109 ++++++++++
 tb/tb_sram_fifo_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller that keeps its entries in an external single-port-per-direction SRAM, plus
// one output staging slot. Define SRAM_FIFO_CTRL_LEVEL_EN to add the registered level port.
module sram_fifo_ctrl #(
  parameter int unsigned AWIDTH = 12,
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [AWIDTH-1:0] sram_write_addr,
  output logic              sram_write_en,
  output logic [DWIDTH-1:0] sram_write_data,
  output logic [AWIDTH-1:0] sram_read_addr,
  output logic              sram_read_en,
  input  logic [DWIDTH-1:0] sram_read_data
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
  ,
  output logic [AWIDTH:0]   level
`endif
);

  localparam logic [AWIDTH:0]   FullCnt  = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LastAddr = AWIDTH'(DEPTH - 1);

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   mem_cnt_q, mem_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              not_full, push, pop, rd_issue;

  always_comb begin
    // Flops are held by the async reset, so only the outputs need rst_n gating.
    not_full = (mem_cnt_q != FullCnt);
    push     = in_valid && not_full;
    pop      = out_valid_q && out_ready;
    rd_issue = (mem_cnt_q != '0) && (!out_valid_q || out_ready);

    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + 1'b1;
    end

    rd_ptr_d = rd_ptr_q;
    if (rd_issue) begin
      rd_ptr_d = (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + 1'b1;
    end

    case ({push, rd_issue})
      2'b10:   mem_cnt_d = mem_cnt_q + 1'b1;
      2'b01:   mem_cnt_d = mem_cnt_q - 1'b1;
      default: mem_cnt_d = mem_cnt_q;
    endcase

    if (rd_issue) begin
      out_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    in_ready        = rst_n && not_full;
    sram_write_en   = rst_n && push;
    sram_write_addr = wr_ptr_q;
    sram_write_data = in_data;
    sram_read_en    = rst_n && rd_issue;
    sram_read_addr  = rd_ptr_q;
    out_valid       = out_valid_q;
    out_data        = sram_read_data;
  end

`ifdef SRAM_FIFO_CTRL_LEVEL_EN
  logic [AWIDTH:0] level_q;

  // Built from next-state values so level tracks mem_cnt + out_valid with no extra lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= mem_cnt_d + {{AWIDTH{1'b0}}, out_valid_d};
    end
  end

  assign level = level_q;
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Scoreboard bench for sram_fifo_ctrl: random and directed traffic against a queue model,
// with a behavioural SRAM attached to the controller.
module tb_sram_fifo_ctrl;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned DP = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] sram_write_addr;
  logic          sram_write_en;
  logic [DW-1:0] sram_write_data;
  logic [AW-1:0] sram_read_addr;
  logic          sram_read_en;
  logic [DW-1:0] sram_read_data;
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
  logic [AW:0]   level;
`endif

  sram_fifo_ctrl #(
    .AWIDTH(AW),
    .DWIDTH(DW),
    .DEPTH (DP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .sram_write_addr(sram_write_addr),
    .sram_write_en  (sram_write_en),
    .sram_write_data(sram_write_data),
    .sram_read_addr (sram_read_addr),
    .sram_read_en   (sram_read_en),
    .sram_read_data (sram_read_data)
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
    ,
    .level          (level)
`endif
  );

  always #5 clk = ~clk;

  // Registered-output SRAM: read data updates only on a read strobe.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (sram_write_en) mem[sram_write_addr] <= sram_write_data;
    if (sram_read_en)  sram_read_data <= mem[sram_read_addr];
  end

  logic [DW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int n_push = 0;
  int n_pop = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  int exp_wr = 0;
  int exp_rd = 0;
  logic          hold_vld = 1'b0;
  logic [DW-1:0] hold_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic wait_empty(input string name, input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Stimulus side of the scoreboard: record every accepted push and address sequencing.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (in_valid && in_ready) begin
        check("wr_en", 64'(sram_write_en), 64'd1);
        check("wr_addr", 64'(sram_write_addr), 64'(exp_wr));
        check("wr_data", 64'(sram_write_data), 64'(in_data));
        exp_q.push_back(in_data);
        n_push++;
        exp_wr = (exp_wr + 1) % DP;
        check("capacity", 64'(exp_q.size() <= DP + 1), 64'd1);
      end
      if (sram_read_en) begin
        check("rd_addr", 64'(sram_read_addr), 64'(exp_rd));
        if (sram_write_en) check("rd_wr_collide", 64'(sram_read_addr != sram_write_addr), 64'd1);
        exp_rd = (exp_rd + 1) % DP;
      end
    end
  end

  // Output monitor: pop and compare, plus stall stability.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (hold_vld && out_valid) check("stall_data", 64'(out_data), 64'(hold_data));
      if (out_valid && !out_ready) check("stall_no_read", 64'(sram_read_en), 64'd0);
      hold_vld  = out_valid && !out_ready;
      hold_data = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_extra: actual pop of %0h, required no pop (empty)", out_data);
        end else begin
          check("pop_data", 64'(out_data), 64'(exp_q.pop_front()));
        end
        n_pop++;
        last_pop_cyc = cyc;
      end
    end else begin
      hold_vld = 1'b0;
    end
  end

`ifdef SRAM_FIFO_CTRL_LEVEL_EN
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n) check("level", 64'(level), 64'(exp_q.size()));
  end
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: actual time %0t, required completion earlier", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int c;
    int base;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = '0;
    out_ready = 1'b0;
    #3;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_wr_en", 64'(sram_write_en), 64'd0);
    check("rst_rd_en", 64'(sram_read_en), 64'd0);
    in_valid = 1'b0;
    #19 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Single push latency.
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hA5A5A5A5;
    @(negedge clk);
    check("lat_wr_en", 64'(sram_write_en), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_n1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_n2_valid", 64'(out_valid), 64'd1);
    check("lat_n2_data", 64'(out_data), 64'hA5A5A5A5);
    @(negedge clk);
    check("lat_n3_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Fill with the output stalled: DEPTH words in SRAM plus one staged.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    base      = n_push;
    for (int i = 0; i < 12; i++) begin
      in_data = 32'h100 + i;
      @(posedge clk); #1;
    end
    check("fill_count", 64'(n_push - base), 64'(DP + 1));
    check("fill_in_ready", 64'(in_ready), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_empty("fill_drain", 30);
    @(negedge clk);
    check("fill_drained_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Back-to-back streaming: last of 100 pops lands exactly 101 cycles after the first push.
    out_ready = 1'b1;
    c         = cyc;
    base      = n_pop;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 30 && n_pop < base + 100; k++) @(posedge clk);
    #1;
    check("stream_pops", 64'(n_pop - base), 64'd100);
    check("stream_last_cyc", 64'(last_pop_cyc), 64'(c + 101));

    // Random traffic with random output stalls.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_empty("rand_drain", 40);
    @(posedge clk); #1;

    // Reset with three entries stored.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'hC0DE0000 + i;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_wr_en", 64'(sram_write_en), 64'd0);
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
    check("mid_rst_level", 64'(level), 64'd0);
`endif
    exp_q.delete();
    exp_wr   = 0;
    exp_rd   = 0;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hDEADBEEF;
    @(negedge clk);
    check("rst_first_addr", 64'(sram_write_addr), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_empty("rst_drain", 10);
    check("rst_push_count", 64'(n_push > 0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
